// File: rtl/counter_pkg.sv
// Shared definitions for the BCD up/down counter slice.
// Holds the digit width, the BCD terminal values and small nibble helpers
// used by both the per-digit cell and the top-level chain logic.
package counter_pkg;

    localparam int          DIGIT_W = 4;
    localparam logic [3:0]  BCD_MAX = 4'd9;
    localparam logic [3:0]  BCD_MIN = 4'd0;

    // A nibble above 9 is not a legal BCD digit.
    function automatic logic bcd_invalid(input logic [DIGIT_W-1:0] nib);
        return (nib > BCD_MAX);
    endfunction

    // Illegal nibbles collapse to zero; legal ones pass through unchanged.
    function automatic logic [DIGIT_W-1:0] bcd_sanitize(input logic [DIGIT_W-1:0] nib);
        if (bcd_invalid(nib)) begin
            return BCD_MIN;
        end else begin
            return nib;
        end
    endfunction

endpackage

// File: rtl/bcd_updown_counter_if.sv
// Control/status bundle of the BCD up/down counter.
//   CLR, LOAD, LDVAL, EN, UP : controls driven by the master
//   Q, TC, OVF               : count, terminal count and sticky wrap flag
// master: drives controls, observes status.  slave: the counter itself.
interface bcd_updown_counter_if #(
    parameter int DIGITS = 4
);
    logic                  CLR;
    logic                  LOAD;
    logic [4*DIGITS-1:0]   LDVAL;
    logic                  EN;
    logic                  UP;
    logic [4*DIGITS-1:0]   Q;
    logic                  TC;
    logic                  OVF;

    modport master (
        output CLR, LOAD, LDVAL, EN, UP,
        input  Q, TC, OVF
    );

    modport slave (
        input  CLR, LOAD, LDVAL, EN, UP,
        output Q, TC, OVF
    );

endinterface

// File: rtl/bcd_digit.sv
// One BCD digit cell of the up/down counter.
//   CLK, RSTdash : clock and asynchronous active-low reset
//   clr, load    : synchronous clear / parallel load (clear wins)
//   ldval        : load nibble, illegal values load as 0
//   step         : advance this digit by one in direction up
//   q            : registered digit value
//   term         : q==9 when counting up, q==0 when counting down
module bcd_digit
    import counter_pkg::*;
(
    input  logic               CLK,
    input  logic               RSTdash,
    input  logic               clr,
    input  logic               load,
    input  logic [DIGIT_W-1:0] ldval,
    input  logic               step,
    input  logic               up,
    output logic [DIGIT_W-1:0] q,
    output logic               term
);

    logic [DIGIT_W-1:0] q_r;
    logic [DIGIT_W-1:0] q_next_s;

    // Next digit value: clear > load > step > hold.
    always_comb begin
        q_next_s = q_r;
        if (clr) begin
            q_next_s = BCD_MIN;
        end else if (load) begin
            q_next_s = bcd_sanitize(ldval);
        end else if (step) begin
            if (up) begin
                // 9 and any corrupted value both roll to 0
                if (q_r >= BCD_MAX) begin
                    q_next_s = BCD_MIN;
                end else begin
                    q_next_s = q_r + 4'd1;
                end
            end else begin
                // A corrupted value is forced to 0 rather than borrowing
                if (bcd_invalid(q_r)) begin
                    q_next_s = BCD_MIN;
                end else if (q_r == BCD_MIN) begin
                    q_next_s = BCD_MAX;
                end else begin
                    q_next_s = q_r - 4'd1;
                end
            end
        end else begin
            q_next_s = q_r;
        end
    end

    // Digit register.
    always_ff @(posedge CLK or negedge RSTdash) begin
        if (!RSTdash) begin
            q_r <= BCD_MIN;
        end else begin
            q_r <= q_next_s;
        end
    end

    // Terminal value in the current direction.
    always_comb begin
        term = 1'b0;
        if (up) begin
            term = (q_r == BCD_MAX);
        end else begin
            term = (q_r == BCD_MIN);
        end
    end

    assign q = q_r;

endmodule

// File: rtl/bcd_updown_counter.sv
// Multi-digit synchronous BCD up/down counter.
//   CLK, RSTdash : clock and asynchronous active-low reset
//   bus (slave)  : CLR/LOAD/LDVAL/EN/UP controls, Q count, TC terminal
//                  count (combinational), OVF sticky wrap flag (registered)
// Digits are chained ripple-free: each digit steps when EN is high and every
// lower digit sits at its terminal value (or holds a corrupted value, which
// carries/borrows as if it were terminal).
module bcd_updown_counter
    import counter_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic                   CLK,
    input  logic                   RSTdash,
    bcd_updown_counter_if.slave    bus
);

    localparam int QW = DIGIT_W * DIGITS;

    logic [QW-1:0]     q_s;
    logic [DIGITS-1:0] term_s;
    logic [DIGITS-1:0] chain_s;
    logic [DIGITS-1:0] step_s;
    logic              all_term_s;
    logic              ovf_r;
    logic              ovf_next_s;

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        bcd_digit u_digit (
            .CLK     (CLK),
            .RSTdash (RSTdash),
            .clr     (bus.CLR),
            .load    (bus.LOAD),
            .ldval   (bus.LDVAL[g*DIGIT_W +: DIGIT_W]),
            .step    (step_s[g]),
            .up      (bus.UP),
            .q       (q_s[g*DIGIT_W +: DIGIT_W]),
            .term    (term_s[g])
        );

        // Carry/borrow propagates through terminal and corrupted digits.
        assign chain_s[g] = term_s[g] | bcd_invalid(q_s[g*DIGIT_W +: DIGIT_W]);
    end

    // Step enables: digit i moves when all digits below it propagate.
    always_comb begin
        logic acc;
        acc    = 1'b1;
        step_s = {DIGITS{1'b0}};
        for (int i = 0; i < DIGITS; i++) begin
            step_s[i] = bus.EN & acc;
            acc       = acc & chain_s[i];
        end
    end

    assign all_term_s = &term_s;

    // Sticky wrap flag: cleared by clear/load, set on a full-range wrap.
    always_comb begin
        ovf_next_s = ovf_r;
        if (bus.CLR) begin
            ovf_next_s = 1'b0;
        end else if (bus.LOAD) begin
            ovf_next_s = 1'b0;
        end else if (bus.EN && all_term_s) begin
            ovf_next_s = 1'b1;
        end else begin
            ovf_next_s = ovf_r;
        end
    end

    // Wrap flag register.
    always_ff @(posedge CLK or negedge RSTdash) begin
        if (!RSTdash) begin
            ovf_r <= 1'b0;
        end else begin
            ovf_r <= ovf_next_s;
        end
    end

    assign bus.Q   = q_s;
    assign bus.OVF = ovf_r;
    // Deliberately not gated by CLR/LOAD; consumers qualify it.
    assign bus.TC  = bus.EN & all_term_s;

endmodule
